spi_afe_slave: RTL and testbench
================================

SPI_AFE_SLAVE -- requirements
Module: spi_afe_slave

Interface
REQ-001 SHALL have parameter ADDR_W, 4, register-index width (2**ADDR_W registers).
REQ-002 SHALL have parameter DATA_W, 16, register and data-field width; frame length is 8+DATA_W bits.
REQ-003 SHALL have port sys_clk  input  1  the single clock for all logic.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port spi_clk_i  input  1  SPI clock from the master, asynchronous to sys_clk.
REQ-006 SHALL have port spi_mosi_i  input  1  serial data from the master.
REQ-007 SHALL have port spi_sel_i  input  1  frame select/latch, active-low.
REQ-008 SHALL have port spi_miso_o  output  1  serial read data to the master.
REQ-009 SHALL have port reg_wr_o  output  1  one-cycle register-write commit strobe.
REQ-010 SHALL have port reg_addr_o  output  ADDR_W  address of the committed write.
REQ-011 SHALL have port reg_wdata_o  output  DATA_W  data of the committed write.
REQ-012 SHALL have port rd_addr_i  input  ADDR_W  fabric register read address.
REQ-013 SHALL have port rd_data_o  output  DATA_W  register contents at rd_addr_i, combinational.
REQ-014 SHALL have port frame_err_o  output  1  one-cycle pulse on a malformed frame.

Function
REQ-015 SHALL pass spi_clk_i, spi_mosi_i and spi_sel_i through 2-FF synchronizers, then detect edges; spi_clk_i period >= 8 sys_clk cycles.
REQ-016 SHALL use SPI mode 0: sample MOSI on synchronized rising SCK, update MISO on falling SCK, MSB first.
REQ-017 SHALL decode frame bit 23 as R/W (1 = read), bits 22:16 as address, bits 15:0 as data.
REQ-018 SHALL use FSM IDLE -> SHIFT on sel falling; SHIFT -> COMMIT on sel rising with exactly 8+DATA_W bits; SHIFT -> ERR on sel rising with any other count; COMMIT/ERR -> IDLE after one cycle.
REQ-019 SHALL, in COMMIT for a write with address bits 22:ADDR_W+16 all zero, update the register and pulse reg_wr_o with reg_addr_o/reg_wdata_o valid in the same cycle.
REQ-020 SHALL silently discard writes to out-of-range addresses: no strobe, no error.
REQ-021 SHALL, for a read, load the addressed register (0 if out of range) into the output shifter on the falling SCK after bit 8, driving data bit 15 first.
REQ-022 SHALL pulse frame_err_o in ERR and discard the frame; bits beyond 8+DATA_W are ignored, the frame still errors.
REQ-023 SHALL make an SPI write visible on rd_data_o the cycle after reg_wr_o.
REQ-024 SHALL hold spi_miso_o at 0 whenever the FSM is not in SHIFT.

Reset
REQ-025 SHALL, while sys_rst_n is low, force state IDLE, all registers 0, spi_miso_o 0, reg_wr_o 0, reg_addr_o 0, reg_wdata_o 0, frame_err_o 0 and bit counter 0.
REQ-026 SHALL, on reset asserted mid-frame, drop the frame; after release, wait for a fresh sel falling edge.

Configuration
REQ-027 SHALL, with SPI_AFE_SLAVE_READBACK_EN defined, implement read frames per REQ-021.
REQ-028 SHALL, without SPI_AFE_SLAVE_READBACK_EN, tie spi_miso_o to 0 and treat read frames as no-ops, with no strobe and no error.

Structure
REQ-029 SHALL place frame-field bit positions, FRAME_BITS and the FSM state encoding in shared package spi_afe_pkg.
REQ-030 SHALL instantiate sub-module spi_afe_sync for the synchronizer plus rise/fall edge detect, one instance per input.

Verification
REQ-031 SHALL cover write frame 0x03_1234 -> reg_wr_o pulses once, reg_addr_o=3, reg_wdata_o=0x1234, then rd_addr_i=3 gives rd_data_o=0x1234.
REQ-032 SHALL cover a write of 0xBEEF to reg 5, then read frame 0x85_0000 -> MISO bits 9..24 equal 0xBEEF (READBACK_EN defined).
REQ-033 SHALL cover sel released after 13 bits of write 0x02_AAAA -> frame_err_o pulses once, reg 2 unchanged, no reg_wr_o.
REQ-034 SHALL cover write to address 0x12 -> no reg_wr_o, no frame_err_o, all registers unchanged; a read of 0x12 returns 0x0000.
REQ-035 SHALL cover sys_rst_n pulsed low at bit 10 of write 0x01_5555, then a clean frame 0x01_0F0F -> reg 1 = 0x0F0F, single strobe.
REQ-036 SHALL cover a build without READBACK_EN and read frame 0x83_0000 -> spi_miso_o constant 0, no strobe, no error.

Source files
------------

// File: rtl/spi_afe_pkg.sv
// ---------------------------------------------------------------------------
// spi_afe_pkg
// Shared definitions for the SPI register slave (spi_afe_slave).
//   - Frame layout for the default 16-bit data field:
//       bit 23     R/W (1 = read)
//       bits 22:16 register address
//       bits 15:0  data
//   - FRAME_BITS: total frame length for the default data width.
//   - afe_state_t: FSM state encoding shared by RTL and anyone probing it.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_afe_pkg;

  localparam int CMD_BITS       = 8;
  localparam int CMD_ADDR_BITS  = 7;
  localparam int CMD_RW_OFS     = 7;
  localparam int DATA_BITS_DEF  = 16;
  localparam int FRAME_BITS     = CMD_BITS + DATA_BITS_DEF;

  localparam int RW_POS         = FRAME_BITS - 1;
  localparam int ADDR_HI_POS    = FRAME_BITS - 2;
  localparam int ADDR_LO_POS    = DATA_BITS_DEF;
  localparam int DATA_HI_POS    = DATA_BITS_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ERR    = 2'd3
  } afe_state_t;

endpackage

// File: rtl/spi_afe_sync.sv
// ---------------------------------------------------------------------------
// spi_afe_sync
// Two-flop synchronizer for one asynchronous SPI pin, followed by a third
// flop used to detect rising and falling edges in the system clock domain.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (all flops clear to 0)
//   i_async  asynchronous input pin
//   o_level  synchronized level
//   o_rise   one-cycle pulse on a synchronized 0->1 transition
//   o_fall   one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_afe_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Clearing to 0 means a pin held low through reset never produces a
  // falling edge afterwards, so an interrupted frame cannot restart itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_afe_slave.sv
// ---------------------------------------------------------------------------
// spi_afe_slave
// SPI mode-0 slave giving an external master write (and optionally read)
// access to a bank of 2**ADDR_W registers of DATA_W bits. All SPI pins are
// oversampled in the sys_clk domain; spi_clk_i must be at least 8 sys_clk
// periods long. A frame is 8+DATA_W bits, MSB first: R/W, 7-bit address,
// data. Frames of the wrong length raise frame_err_o and are discarded.
//
// Optional feature macro: SPI_AFE_SLAVE_READBACK_EN
//   defined   : read frames shift the addressed register out on spi_miso_o
//   undefined : spi_miso_o is tied 0 and read frames are no-ops
//
// Ports:
//   sys_clk      system clock
//   sys_rst_n    asynchronous active-low reset
//   spi_clk_i    SPI clock (async)
//   spi_mosi_i   SPI data in (async)
//   spi_sel_i    SPI select, active-low (async)
//   spi_miso_o   SPI data out, 0 outside a frame
//   reg_wr_o     one-cycle write commit strobe
//   reg_addr_o   address of the committed write
//   reg_wdata_o  data of the committed write
//   rd_addr_i    fabric read address
//   rd_data_o    register contents at rd_addr_i (combinational)
//   frame_err_o  one-cycle pulse on a malformed frame
// ---------------------------------------------------------------------------
module spi_afe_slave
  import spi_afe_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_sel_i,
  output logic              spi_miso_o,
  output logic              reg_wr_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              frame_err_o
);

  // Field positions scale with DATA_W; the package gives them for 16 bits.
  localparam int FRAME_W = FRAME_BITS  - DATA_BITS_DEF + DATA_W;
  localparam int RW_BIT  = RW_POS      - DATA_BITS_DEF + DATA_W;
  localparam int ADDR_HI = ADDR_HI_POS - DATA_BITS_DEF + DATA_W;
  localparam int ADDR_LO = ADDR_LO_POS - DATA_BITS_DEF + DATA_W;
  localparam int DATA_HI = DATA_HI_POS - DATA_BITS_DEF + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  afe_state_t r_state;
  afe_state_t w_nextState;

  logic [FRAME_W-1:0]       r_shift;
  logic [CNT_W-1:0]         r_bitCnt;
  logic                     r_regWr;
  logic [ADDR_W-1:0]        r_regAddr;
  logic [DATA_W-1:0]        r_regWdata;
  logic                     r_frameErr;
  logic [DATA_W-1:0]        r_regs [2**ADDR_W];

  logic w_sckLevel, w_sckRise, w_sckFall;
  logic w_mosiLevel, w_mosiRise, w_mosiFall;
  logic w_selLevel, w_selRise, w_selFall;

  logic [CMD_ADDR_BITS-1:0] w_frameAddr;
  logic                     w_frameInRange;
  logic                     w_frameIsWrite;
  logic                     w_frameDone;
  logic                     w_frameLenOk;
  logic                     w_frameStart;
  logic                     w_unused;

  spi_afe_sync u_syncSck (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_async (spi_clk_i),
    .o_level (w_sckLevel),
    .o_rise  (w_sckRise),
    .o_fall  (w_sckFall)
  );

  spi_afe_sync u_syncMosi (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_async (spi_mosi_i),
    .o_level (w_mosiLevel),
    .o_rise  (w_mosiRise),
    .o_fall  (w_mosiFall)
  );

  spi_afe_sync u_syncSel (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_async (spi_sel_i),
    .o_level (w_selLevel),
    .o_rise  (w_selRise),
    .o_fall  (w_selFall)
  );

  assign w_unused = &{1'b0, w_sckLevel, w_sckFall, w_mosiRise, w_mosiFall,
                      w_selLevel};

  // Decode of a complete frame as it sits in the shifter at sel release.
  // Only the low ADDR_W address bits are implemented; anything above is
  // treated as out of range.
  assign w_frameAddr    = r_shift[ADDR_HI:ADDR_LO];
  assign w_frameInRange = ((w_frameAddr >> ADDR_W) == '0);
  assign w_frameIsWrite = ~r_shift[RW_BIT];
  assign w_frameStart   = (r_state == ST_IDLE) && w_selFall;
  assign w_frameDone    = (r_state == ST_SHIFT) && w_selRise;
  assign w_frameLenOk   = (r_bitCnt == CNT_FRAME);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // COMMIT and ERR last exactly one cycle so their strobes are single pulses.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_selFall) w_nextState = ST_SHIFT;
      ST_SHIFT:  if (w_selRise) w_nextState = w_frameLenOk ? ST_COMMIT : ST_ERR;
      ST_COMMIT: w_nextState = ST_IDLE;
      ST_ERR:    w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Input shifter and bit counter. The counter saturates so that an
  // arbitrarily long frame can never wrap back onto the legal length.
  // The commit/error strobes are registered on the SHIFT exit edge, which
  // makes them high exactly during the COMMIT/ERR state cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_regWr    <= 1'b0;
      r_regAddr  <= '0;
      r_regWdata <= '0;
      r_frameErr <= 1'b0;
    end else begin
      r_regWr    <= 1'b0;
      r_frameErr <= 1'b0;
      if (w_frameStart) begin
        r_shift  <= '0;
        r_bitCnt <= '0;
      end else if ((r_state == ST_SHIFT) && w_sckRise) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_mosiLevel};
        if (r_bitCnt != CNT_MAX) begin
          r_bitCnt <= r_bitCnt + 1'b1;
        end
      end
      if (w_frameDone) begin
        if (!w_frameLenOk) begin
          r_frameErr <= 1'b1;
        end else if (w_frameIsWrite && w_frameInRange) begin
          r_regWr    <= 1'b1;
          r_regAddr  <= w_frameAddr[ADDR_W-1:0];
          r_regWdata <= r_shift[DATA_HI:0];
        end
      end
    end
  end

  // The bank is updated at the end of the COMMIT cycle, so fabric reads
  // see the new value one cycle after the strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_regWr) begin
      r_regs[r_regAddr] <= r_regWdata;
    end
  end

  assign rd_data_o   = r_regs[rd_addr_i];
  assign reg_wr_o    = r_regWr;
  assign reg_addr_o  = r_regAddr;
  assign reg_wdata_o = r_regWdata;
  assign frame_err_o = r_frameErr;

`ifdef SPI_AFE_SLAVE_READBACK_EN
  logic [DATA_W-1:0]        r_misoShift;
  logic [CMD_ADDR_BITS-1:0] w_cmdAddr;
  logic                     w_cmdIsRead;
  logic                     w_cmdInRange;
  logic [DATA_W-1:0]        w_cmdRdVal;

  // After 8 bits the command byte occupies the low end of the shifter.
  assign w_cmdAddr    = r_shift[CMD_ADDR_BITS-1:0];
  assign w_cmdIsRead  = r_shift[CMD_RW_OFS];
  assign w_cmdInRange = ((w_cmdAddr >> ADDR_W) == '0);
  assign w_cmdRdVal   = w_cmdInRange ? r_regs[w_cmdAddr[ADDR_W-1:0]] : '0;

  // Output shifter: loaded on the falling SCK that ends the command byte,
  // so the master samples data MSB on its 9th rising edge; later falling
  // edges shift the next bit up. Writes leave it at zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_misoShift <= '0;
    end else if (w_frameStart) begin
      r_misoShift <= '0;
    end else if ((r_state == ST_SHIFT) && w_sckFall) begin
      if (r_bitCnt == CNT_CMD) begin
        r_misoShift <= w_cmdIsRead ? w_cmdRdVal : '0;
      end else begin
        r_misoShift <= {r_misoShift[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign spi_miso_o = (r_state == ST_SHIFT) & r_misoShift[DATA_W-1];
`else
  assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_afe_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_afe_slave
// Scoreboard testbench for spi_afe_slave. Directed SPI frames are driven
// bit by bit; expected write strobes and error pulses are queued before each
// frame and a separate monitor pops and compares them whenever the DUT
// raises reg_wr_o or frame_err_o. MISO data and fabric reads are compared
// directly against hand-computed values. Works with or without
// SPI_AFE_SLAVE_READBACK_EN defined.
// ---------------------------------------------------------------------------
module tb_spi_afe_slave;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int HALF   = 8;

`ifdef SPI_AFE_SLAVE_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              spi_clk_i = 1'b0;
  logic              spi_mosi_i = 1'b0;
  logic              spi_sel_i = 1'b1;
  logic              spi_miso_o;
  logic              reg_wr_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [DATA_W-1:0] reg_wdata_o;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic [DATA_W-1:0] rd_data_o;
  logic              frame_err_o;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                frame;
  } wr_t;

  wr_t               wrQ[$];
  int                errQ[$];
  wr_t               monWr;
  int                monErr;
  logic [DATA_W-1:0] expRegs [2**ADDR_W];
  int                frameNo = 0;
  int                checks = 0;
  int                failures = 0;
  logic [23:0]       misoBits;

  spi_afe_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .spi_clk_i   (spi_clk_i),
    .spi_mosi_i  (spi_mosi_i),
    .spi_sel_i   (spi_sel_i),
    .spi_miso_o  (spi_miso_o),
    .reg_wr_o    (reg_wr_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .frame_err_o (frame_err_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Queue a write strobe for the next frame and update the register model.
  task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr  = a;
    e.data  = d;
    e.frame = frameNo + 1;
    wrQ.push_back(e);
    expRegs[a] = d;
  endtask

  task automatic expectErr();
    errQ.push_back(frameNo + 1);
  endtask

  // Drive one SPI mode-0 frame; MISO is sampled just before each rising SCK.
  task automatic applyStimulus(input logic [23:0] frame, input int nbits,
                               input bit releaseSel, output logic [23:0] miso);
    frameNo++;
    miso = '0;
    spi_sel_i = 1'b0;
    repeat (HALF) @(posedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 24) spi_mosi_i = frame[23-i];
      else        spi_mosi_i = 1'b0;
      repeat (HALF) @(posedge sys_clk);
      #1;
      if (i < 24) miso = {miso[22:0], spi_miso_o};
      spi_clk_i = 1'b1;
      repeat (HALF) @(posedge sys_clk);
      spi_clk_i = 1'b0;
    end
    repeat (HALF) @(posedge sys_clk);
    spi_mosi_i = 1'b0;
    if (releaseSel) begin
      spi_sel_i = 1'b1;
      repeat (3*HALF) @(posedge sys_clk);
    end
  endtask

  task automatic checkRd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                         input string name);
    rd_addr_i = a;
    @(negedge sys_clk);
    checkOutput(name, rd_data_o, exp);
  endtask

  // Monitor: every strobe or error pulse must match the head of its queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (reg_wr_o) begin
        if (wrQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_reg_wr actual addr=0x%0h data=0x%0h expected none",
                   reg_addr_o, reg_wdata_o);
        end else begin
          monWr = wrQ.pop_front();
          checkOutput("reg_wr_frame", frameNo, monWr.frame);
          checkOutput("reg_addr", reg_addr_o, monWr.addr);
          checkOutput("reg_wdata", reg_wdata_o, monWr.data);
        end
      end
      if (frame_err_o) begin
        if (errQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_frame_err actual frame=%0d expected none", frameNo);
        end else begin
          monErr = errQ.pop_front();
          checkOutput("frame_err_frame", frameNo, monErr);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) expRegs[i] = '0;

    // Reset state
    repeat (5) @(posedge sys_clk);
    #1;
    checkOutput("rst_reg_wr", reg_wr_o, 0);
    checkOutput("rst_frame_err", frame_err_o, 0);
    checkOutput("rst_miso", spi_miso_o, 0);
    checkOutput("rst_reg_addr", reg_addr_o, 0);
    checkOutput("rst_reg_wdata", reg_wdata_o, 0);
    checkOutput("rst_rd_data", rd_data_o, 0);
    sys_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);

    // Basic write and fabric readback
    expectWrite(4'd3, 16'h1234);
    applyStimulus(24'h03_1234, 24, 1'b1, misoBits);
    checkRd(4'd3, 16'h1234, "rd_reg3");

    expectWrite(4'd5, 16'hBEEF);
    applyStimulus(24'h05_BEEF, 24, 1'b1, misoBits);
    checkRd(4'd5, 16'hBEEF, "rd_reg5");

    // Read frames: data on MISO only with readback built in
    applyStimulus(24'h85_0000, 24, 1'b1, misoBits);
    checkOutput("miso_read5", misoBits, READBACK ? 24'h00BEEF : 24'h000000);
    applyStimulus(24'h83_0000, 24, 1'b1, misoBits);
    checkOutput("miso_read3", misoBits, READBACK ? 24'h001234 : 24'h000000);

    // Short frame: error, nothing written
    expectErr();
    applyStimulus(24'h02_AAAA, 13, 1'b1, misoBits);
    checkRd(4'd2, 16'h0000, "rd_reg2_short");

    // Over-long frame: error, nothing written
    expectErr();
    applyStimulus(24'h04_1111, 26, 1'b1, misoBits);
    checkRd(4'd4, 16'h0000, "rd_reg4_long");

    // Out-of-range write is silently dropped
    applyStimulus(24'h12_5A5A, 24, 1'b1, misoBits);
    for (int i = 0; i < 2**ADDR_W; i++) begin
      checkRd(ADDR_W'(i), expRegs[i], $sformatf("rd_bank_%0d", i));
    end
    applyStimulus(24'h92_0000, 24, 1'b1, misoBits);
    checkOutput("miso_read_oor", misoBits, 24'h000000);

    // Reset in the middle of a write frame
    applyStimulus(24'h01_5555, 10, 1'b0, misoBits);
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 2**ADDR_W; i++) expRegs[i] = '0;
    checkOutput("midrst_reg_wr", reg_wr_o, 0);
    rd_addr_i = 4'd3;
    #1;
    checkOutput("midrst_rd_reg3", rd_data_o, 0);
    sys_rst_n = 1'b1;
    repeat (HALF) @(posedge sys_clk);
    spi_sel_i = 1'b1;
    repeat (3*HALF) @(posedge sys_clk);
    checkRd(4'd1, 16'h0000, "rd_reg1_after_rst");

    expectWrite(4'd1, 16'h0F0F);
    applyStimulus(24'h01_0F0F, 24, 1'b1, misoBits);
    checkRd(4'd1, 16'h0F0F, "rd_reg1_clean");
    checkRd(4'd5, 16'h0000, "rd_reg5_cleared");

    repeat (20) @(posedge sys_clk);
    checkOutput("wr_queue_left", wrQ.size(), 0);
    checkOutput("err_queue_left", errQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
